ins_mem_loader: RTL and testbench

Boot-time writer for the instruction memory's write port. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives write_enable/write_address/write_data with consecutive word indices. It holds the CPU in reset until a complete frame has been loaded and its checksum verified.

---
 rtl/ins_mem_loader.sv | 156 +++++++++++++++
 tb/tb_ins_mem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
// ins_mem_loader: framed byte-stream boot loader driving the instruction memory write port.
// Optional macro LOADER_TIMEOUT_EN aborts a frame stalled for TIMEOUT_CYCLES cycles.
module ins_mem_loader #(
   parameter int unsigned MEM_SIZE       = 64,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        write_enable,
   output logic [31:0] write_address,
   output logic [31:0] write_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_hold
);
   typedef enum logic [2:0] {
      S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   localparam logic [16:0] CAPACITY = 17'(MEM_SIZE - BASE_ADDR);
   localparam logic [31:0] BASE     = 32'(BASE_ADDR);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] word_buf_q, word_buf_d;
   logic [7:0]  csum_q, csum_d;
   logic        we_q, we_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        accept;
   logic        tmo_hit;

   // Handshake: a byte moves on the posedge where rx_valid && rx_ready; ready is high whenever reset is released.
   assign rx_ready = reset;
   assign accept   = rx_valid & rx_ready;

   assign busy          = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERROR);
   assign cpu_hold      = (state_q != S_DONE);
   assign write_enable  = we_q;
   assign write_address = waddr_q;
   assign write_data    = wdata_q;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d   = '0;
      tmo_hit = 1'b0;
      if (busy && !accept) begin
         tmo_d   = tmo_q + TMO_W'(1);
         tmo_hit = (tmo_d == TMO_W'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
   end
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      word_buf_d = word_buf_q;
      csum_d     = csum_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      if (accept) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (rx_data == 8'hA5) begin
                  state_d    = S_CNT_LO;
                  count_d    = '0;
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  csum_d     = '0;
               end
            end
            S_CNT_LO: begin
               count_d = {8'h00, rx_data};
               csum_d  = csum_q ^ rx_data;
               state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
               count_d = {rx_data, count_q[7:0]};
               csum_d  = csum_q ^ rx_data;
               // 17-bit compare so a full 16-bit count never wraps past the capacity.
               if ({1'b0, count_d} > CAPACITY) state_d = S_ERROR;
               else if (count_d == 16'd0)      state_d = S_CSUM;
               else                            state_d = S_DATA;
            end
            S_DATA: begin
               csum_d     = csum_q ^ rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: word_buf_d[7:0]   = rx_data;
                  2'd1: word_buf_d[15:8]  = rx_data;
                  2'd2: word_buf_d[23:16] = rx_data;
                  default: begin
                     we_d       = 1'b1;
                     wdata_d    = {rx_data, word_buf_q};
                     waddr_d    = BASE + {16'h0000, word_idx_q};
                     word_idx_d = word_idx_q + 16'd1;
                     if (word_idx_d == count_q) state_d = S_CSUM;
                  end
               endcase
            end
            S_CSUM:  state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end
      if (tmo_hit) state_d = S_ERROR;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         word_buf_q <= '0;
         csum_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_buf_q <= word_buf_d;
         csum_q     <= csum_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end
endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: frames in, write pulses and status flags checked.
// The timeout scenario is compiled in only when LOADER_TIMEOUT_EN is defined.
module tb_ins_mem_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready, write_enable, busy, done, error, cpu_hold;
   logic [31:0] write_address, write_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   logic [63:0] exp_q[$];
   logic [63:0] act_q[$];
   int exp_cyc_q[$];
   int act_cyc_q[$];

   ins_mem_loader #(.MEM_SIZE(64), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
      .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor: every cycle with write_enable high is one captured write.
   always @(negedge clk) begin
      if (write_enable) begin
         act_q.push_back({write_address, write_data});
         act_cyc_q.push_back(cyc);
      end
   end

   task automatic clear_queues();
      exp_q.delete(); act_q.delete(); exp_cyc_q.delete(); act_cyc_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      reset    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b exp 0", rx_ready); end
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", write_enable); end
      checks++; if (write_address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", write_address); end
      checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", write_data); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         errors++; $display("FAIL rst_flags: got busy=%b done=%b error=%b exp 0 0 0", busy, done, error); end
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b exp 1", cpu_hold); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", rx_ready); end
   endtask

   task automatic test_good_load();
      logic [7:0] f [12];
      f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
      clear_queues();
      exp_q.push_back({32'd0, 32'h00500093});
      exp_q.push_back({32'd1, 32'h00A00113});
      for (int i = 0; i < 12; i++) begin
         send_byte(f[i]);
         if (i == 6 || i == 10) exp_cyc_q.push_back(last_acc_cyc);
         if (i == 1) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b exp 1", busy); end
         end
      end
      idle(0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b exp 1", done); end
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL good_cpu_hold: got %b exp 0", cpu_hold); end
      checks++; if (error !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL good_err_busy: got error=%b busy=%b exp 0 0", error, busy); end
      checks++; if (write_address !== 32'd1 || write_data !== 32'h00A00113) begin
         errors++; $display("FAIL good_hold: got %h/%h exp 00000001/00a00113", write_address, write_data); end
      checks++; if (act_q.size() != 2) begin errors++; $display("FAIL good_wr_count: got %0d exp 2", act_q.size()); end
      for (int i = 0; i < act_q.size() && i < 2; i++) begin
         checks++;
         if (act_q[i] !== exp_q[i] || act_cyc_q[i] != exp_cyc_q[i]) begin
            errors++; $display("FAIL good_wr%0d: got %h @%0d exp %h @%0d", i, act_q[i], act_cyc_q[i], exp_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] f [12];
      f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h72};
      clear_queues();
      exp_q.push_back({32'd0, 32'h00500093});
      exp_q.push_back({32'd1, 32'h00A00113});
      for (int i = 0; i < 12; i++) send_byte(f[i]);
      idle(0);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL badcs_error: got %b exp 1", error); end
      checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin
         errors++; $display("FAIL badcs_done_hold: got done=%b cpu_hold=%b exp 0 1", done, cpu_hold); end
      checks++; if (act_q.size() != 2) begin errors++; $display("FAIL badcs_wr_count: got %0d exp 2", act_q.size()); end
      for (int i = 0; i < act_q.size() && i < 2; i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL badcs_wr%0d: got %h exp %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_oversize();
      clear_queues();
      send_byte(8'hA5); send_byte(8'h41); send_byte(8'h00);
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL over_error: got error=%b busy=%b exp 1 0", error, busy); end
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      idle(1);
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL over_ignore: got error=%b busy=%b exp 1 0", error, busy); end
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL over_no_wr: got %0d exp 0", act_q.size()); end
   endtask

   task automatic test_garbage_zero_len();
      clear_queues();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garb_busy: got %b exp 0", busy); end
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      idle(0);
      checks++; if (done !== 1'b1 || error !== 1'b0) begin
         errors++; $display("FAIL zero_done: got done=%b error=%b exp 1 0", done, error); end
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL zero_no_wr: got %0d exp 0", act_q.size()); end
      send_byte(8'hA5);
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL restart_clear: got done=%b busy=%b exp 0 1", done, busy); end
      idle(0);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] f [12];
      f = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
      do_reset();
      clear_queues();
      for (int i = 0; i < 5; i++) send_byte(f[i]);
      @(negedge clk);
      rx_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_flags: got busy=%b done=%b error=%b hold=%b ready=%b exp 0 0 0 1 0",
                            busy, done, error, cpu_hold, rx_ready); end
      checks++; if (write_enable !== 1'b0 || write_address !== 32'h0 || write_data !== 32'h0) begin
         errors++; $display("FAIL midrst_port: got we=%b %h/%h exp 0 0/0", write_enable, write_address, write_data); end
      reset = 1'b1;
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL midrst_no_wr: got %0d exp 0", act_q.size()); end
      exp_q.push_back({32'd0, 32'h00500093});
      exp_q.push_back({32'd1, 32'h00A00113});
      for (int i = 0; i < 12; i++) send_byte(f[i]);
      idle(0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_reload_done: got %b exp 1", done); end
      checks++; if (act_q.size() != 2) begin errors++; $display("FAIL midrst_wr_count: got %0d exp 2", act_q.size()); end
      for (int i = 0; i < act_q.size() && i < 2; i++) begin
         checks++;
         if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_wr%0d: got %h exp %h", i, act_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_full_size();
      logic [7:0]  b;
      logic [7:0]  cs;
      logic [31:0] w;
      clear_queues();
      cs = 8'h40;
      send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
      for (int n = 0; n < 64; n++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(4 * n + k);
            cs = cs ^ b;
            w[8*k +: 8] = b;
            send_byte(b);
         end
         exp_q.push_back({32'(n), w});
         exp_cyc_q.push_back(last_acc_cyc);
      end
      send_byte(cs);
      idle(0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b exp 1", done); end
      checks++; if (act_q.size() != 64) begin errors++; $display("FAIL full_wr_count: got %0d exp 64", act_q.size()); end
      for (int i = 0; i < act_q.size() && i < 64; i++) begin
         checks++;
         if (act_q[i] !== exp_q[i] || act_cyc_q[i] != exp_cyc_q[i]) begin
            errors++; $display("FAIL full_wr%0d: got %h @%0d exp %h @%0d", i, act_q[i], act_cyc_q[i], exp_q[i], exp_cyc_q[i]);
         end
      end
   endtask

   task automatic test_gaps_and_inner_a5();
      logic [7:0] f [8];
      f = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};
      clear_queues();
      exp_q.push_back({32'd0, 32'hA5A5A5A5});
      for (int i = 0; i < 8; i++) begin
         send_byte(f[i]);
         if (i == 6) exp_cyc_q.push_back(last_acc_cyc);
         idle(2);
         if (i == 4) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b exp 1", busy); end
         end
      end
      checks++; if (done !== 1'b1 || error !== 1'b0) begin
         errors++; $display("FAIL gap_done: got done=%b error=%b exp 1 0", done, error); end
      checks++; if (act_q.size() != 1) begin errors++; $display("FAIL gap_wr_count: got %0d exp 1", act_q.size()); end
      if (act_q.size() > 0) begin
         checks++;
         if (act_q[0] !== exp_q[0] || act_cyc_q[0] != exp_cyc_q[0]) begin
            errors++; $display("FAIL gap_wr0: got %h @%0d exp %h @%0d", act_q[0], act_cyc_q[0], exp_q[0], exp_cyc_q[0]);
         end
      end
   endtask

`ifdef LOADER_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      clear_queues();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h93);
      idle(0);
      repeat (15) @(negedge clk);
      checks++; if (error !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL tmo_early: got error=%b busy=%b exp 0 1", error, busy); end
      @(negedge clk);
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL tmo_hit: got error=%b busy=%b exp 1 0", error, busy); end
      checks++; if (act_q.size() != 0) begin errors++; $display("FAIL tmo_no_wr: got %0d exp 0", act_q.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_oversize();
      test_garbage_zero_len();
      test_reset_mid_frame();
      test_full_size();
      test_gaps_and_inner_a5();
`ifdef LOADER_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
